mcu_pixel_sequencer: RTL and testbench

- Stage directly upstream of ycbcr2rgb in the JPEG decoder.
- Accepts the IDCT output for one 4:4:4 MCU as three serial 8x8 blocks: Y, then Cb, then Cr. Each block is 64 signed level-shifted samples in raster order.
- Buffers each MCU in a two-bank ping-pong store and emits 64 (y, cb, cr) triplets, one per cycle, with valid/ready handshake, ready for colour conversion.

---
 rtl/jpeg_pkg.sv | 23 ++
 rtl/mcu_pixel_sequencer_if.sv | 39 +++
 rtl/mcu_bank_ram.sv | 45 ++++
 rtl/mcu_pixel_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mcu_pixel_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder definitions: sample type, block geometry and
// component numbering used by the MCU pixel sequencer and its RAM.
package jpeg_pkg;

    localparam int DATA_W  = 8;
    localparam int BLK_PIX = 64;
    localparam int IDX_W   = 6;
    localparam int N_COMP  = 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [1:0]               comp_t;
    typedef logic [IDX_W-1:0]         idx_t;

    localparam comp_t COMP_Y  = 2'd0;
    localparam comp_t COMP_CB = 2'd1;
    localparam comp_t COMP_CR = 2'd2;

    // True for the final sample position of an 8x8 block
    function automatic logic is_last_idx(input idx_t idx);
        return idx == idx_t'(BLK_PIX - 1);
    endfunction

endpackage

// File: rtl/mcu_pixel_sequencer_if.sv
// Stream bundle for the MCU pixel sequencer: serial IDCT samples in,
// (y, cb, cr) triplets out. Optional macro PIX_COORD_EN adds the
// row/column of each emitted pixel.
interface mcu_pixel_sequencer_if;
    import jpeg_pkg::*;

    sample_t din;
    logic    din_vld;
    logic    din_rdy;
    sample_t y;
    sample_t cb;
    sample_t cr;
    logic    vld_o;
    logic    rdy_o;
    logic    last_o;
`ifdef PIX_COORD_EN
    logic [2:0] col_o;
    logic [2:0] row_o;

    modport master (
        output din, din_vld, rdy_o,
        input  din_rdy, y, cb, cr, vld_o, last_o, col_o, row_o
    );
    modport slave (
        input  din, din_vld, rdy_o,
        output din_rdy, y, cb, cr, vld_o, last_o, col_o, row_o
    );
`else
    modport master (
        output din, din_vld, rdy_o,
        input  din_rdy, y, cb, cr, vld_o, last_o
    );
    modport slave (
        input  din, din_vld, rdy_o,
        output din_rdy, y, cb, cr, vld_o, last_o
    );
`endif

endinterface

// File: rtl/mcu_bank_ram.sv
// Ping-pong MCU store: 2 banks x 3 components x 64 samples.
// One write port; three parallel combinational read ports (one per
// component) so a full triplet can be fetched every cycle.
module mcu_bank_ram
    import jpeg_pkg::*;
(
    input  logic    clk,
    input  logic    wr_en,
    input  logic    wr_bank,
    input  comp_t   wr_comp,
    input  idx_t    wr_idx,
    input  sample_t wr_data,
    input  logic    rd_bank,
    input  idx_t    rd_idx,
    output sample_t rd_y,
    output sample_t rd_cb,
    output sample_t rd_cr
);

    localparam int DEPTH = 2 * BLK_PIX;

    sample_t rd_word [N_COMP];

    genvar gi;
    generate
        for (gi = 0; gi < N_COMP; gi++) begin : g_comp
            // One array per component, addressed by {bank, index}
            sample_t mem [DEPTH];

            // Store the incoming sample when it belongs to this component
            always_ff @(posedge clk) begin
                if (wr_en && (wr_comp == comp_t'(gi))) begin
                    mem[{wr_bank, wr_idx}] <= wr_data;
                end
            end

            assign rd_word[gi] = mem[{rd_bank, rd_idx}];
        end
    endgenerate

    assign rd_y  = rd_word[COMP_Y];
    assign rd_cb = rd_word[COMP_CB];
    assign rd_cr = rd_word[COMP_CR];

endmodule

// File: rtl/mcu_pixel_sequencer.sv
// MCU pixel sequencer: collects one 4:4:4 MCU (Y, Cb, Cr blocks in
// series) into a ping-pong store and replays it as 64 (y, cb, cr)
// triplets for colour conversion.
// Optional macro PIX_COORD_EN: adds col_o/row_o of each emitted pixel.
module mcu_pixel_sequencer
    import jpeg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mcu_pixel_sequencer_if.slave bus
);

    // Bank occupancy and write/read cursors
    logic [1:0] bank_full_reg;
    logic [1:0] bank_set;
    logic [1:0] bank_clr;
    logic       wr_bank_reg, wr_bank_next;
    comp_t      wr_comp_reg, wr_comp_next;
    idx_t       wr_idx_reg,  wr_idx_next;
    logic       rd_bank_reg, rd_bank_next;
    idx_t       rd_idx_reg,  rd_idx_next;

    // Output register
    sample_t    y_reg, cb_reg, cr_reg;
    logic       vld_reg, last_reg;

    // RAM read data for the current read cursor
    sample_t    ram_y, ram_cb, ram_cr;

    logic       din_rdy;
    logic       wr_fire;
    logic       wr_blk_end;
    logic       wr_mcu_end;
    logic       load;
    logic       rd_mcu_end;

    // A bank can only be written once the reader has drained it
    assign din_rdy    = ~bank_full_reg[wr_bank_reg];
    assign wr_fire    = bus.din_vld & din_rdy;
    assign wr_blk_end = wr_fire & is_last_idx(wr_idx_reg);
    assign wr_mcu_end = wr_blk_end & (wr_comp_reg == COMP_CR);

    // Load a new triplet whenever the output register is empty or leaving
    assign load       = bank_full_reg[rd_bank_reg] & (~vld_reg | bus.rdy_o);
    assign rd_mcu_end = load & is_last_idx(rd_idx_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi] = wr_mcu_end & (wr_bank_reg == 1'(gi));
            assign bank_clr[gi] = rd_mcu_end & (rd_bank_reg == 1'(gi));
        end
    endgenerate

    // Write cursor: index, then component, then bank
    always_comb begin
        wr_idx_next  = wr_idx_reg;
        wr_comp_next = wr_comp_reg;
        wr_bank_next = wr_bank_reg;
        if (wr_fire) begin
            wr_idx_next = wr_idx_reg + idx_t'(1);
        end
        if (wr_blk_end) begin
            wr_idx_next  = '0;
            wr_comp_next = (wr_comp_reg == COMP_CR) ? COMP_Y : wr_comp_reg + comp_t'(1);
        end
        if (wr_mcu_end) begin
            wr_bank_next = ~wr_bank_reg;
        end
    end

    // Read cursor: index, then bank
    always_comb begin
        rd_idx_next  = rd_idx_reg;
        rd_bank_next = rd_bank_reg;
        if (load) begin
            rd_idx_next = rd_idx_reg + idx_t'(1);
        end
        if (rd_mcu_end) begin
            rd_idx_next  = '0;
            rd_bank_next = ~rd_bank_reg;
        end
    end

    // Cursor and occupancy state; set and clear never hit the same bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_reg <= '0;
            wr_bank_reg   <= 1'b0;
            wr_comp_reg   <= COMP_Y;
            wr_idx_reg    <= '0;
            rd_bank_reg   <= 1'b0;
            rd_idx_reg    <= '0;
        end else begin
            bank_full_reg <= (bank_full_reg | bank_set) & ~bank_clr;
            wr_bank_reg   <= wr_bank_next;
            wr_comp_reg   <= wr_comp_next;
            wr_idx_reg    <= wr_idx_next;
            rd_bank_reg   <= rd_bank_next;
            rd_idx_reg    <= rd_idx_next;
        end
    end

    // Output triplet register; holds steady while stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg    <= '0;
            cb_reg   <= '0;
            cr_reg   <= '0;
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
        end else if (load) begin
            y_reg    <= ram_y;
            cb_reg   <= ram_cb;
            cr_reg   <= ram_cr;
            vld_reg  <= 1'b1;
            last_reg <= is_last_idx(rd_idx_reg);
        end else if (bus.rdy_o) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
        end
    end

`ifdef PIX_COORD_EN
    logic [2:0] col_reg, row_reg;

    // Pixel coordinates travel alongside the triplet they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (load) begin
            col_reg <= rd_idx_reg[2:0];
            row_reg <= rd_idx_reg[5:3];
        end
    end

    assign bus.col_o = col_reg;
    assign bus.row_o = row_reg;
`endif

    mcu_bank_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank_reg),
        .wr_comp (wr_comp_reg),
        .wr_idx  (wr_idx_reg),
        .wr_data (bus.din),
        .rd_bank (rd_bank_reg),
        .rd_idx  (rd_idx_reg),
        .rd_y    (ram_y),
        .rd_cb   (ram_cb),
        .rd_cr   (ram_cr)
    );

    assign bus.din_rdy = din_rdy;
    assign bus.y       = y_reg;
    assign bus.cb      = cb_reg;
    assign bus.cr      = cr_reg;
    assign bus.vld_o   = vld_reg;
    assign bus.last_o  = last_reg;

endmodule

// File: tb/tb_mcu_pixel_sequencer.sv
// Scoreboard bench for mcu_pixel_sequencer. Stimulus pushes expected
// triplets when an MCU has been fully accepted; a monitor pops and
// compares on every output transfer. Honours PIX_COORD_EN.
module tb_mcu_pixel_sequencer;
    import jpeg_pkg::*;

    typedef struct {
        sample_t y;
        sample_t cb;
        sample_t cr;
        logic    last;
        int      idx;
        logic    pat0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mcu_pixel_sequencer_if bus();

    mcu_pixel_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   rdy_mode  = 0;
    int   mcu_n     = 0;
    int   stalls    = 0;
    int   mcu_out   = 0;
    bit   contig_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample value of MCU m, component comp, position idx
    function automatic sample_t pix(input int m, input int comp, input int idx);
        if (m == 0) begin
            case (comp)
                0:       return sample_t'(idx - 64);
                1:       return sample_t'(idx - 32);
                default: return sample_t'(-idx);
            endcase
        end
        return sample_t'((idx * 5 + m * 37 + comp * 71 + 3) & 255);
    endfunction

    // Downstream ready generator: 0 = stalled, 1 = always, 2 = random 50%
    initial begin
        bus.rdy_o = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rdy_o = 1'b0;
                1:       bus.rdy_o = 1'b1;
                default: bus.rdy_o = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each transfer and checks stability under stall
    initial begin
        exp_t    e;
        bit      prev_stall;
        sample_t hy, hcb, hcr;
        int      first_cyc;
        prev_stall = 1'b0;
        first_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.vld_o) begin
                if (prev_stall) begin
                    chk("hold_y",  int'(bus.y),  int'(hy));
                    chk("hold_cb", int'(bus.cb), int'(hcb));
                    chk("hold_cr", int'(bus.cr), int'(hcr));
                end
                if (bus.rdy_o) begin
                    prev_stall = 1'b0;
                    chk("sb_has_entry", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("y",      int'(bus.y),      int'(e.y));
                        chk("cb",     int'(bus.cb),     int'(e.cb));
                        chk("cr",     int'(bus.cr),     int'(e.cr));
                        chk("last_o", int'(bus.last_o), int'(e.last));
                        if (e.pat0 && e.idx == 5) begin
                            chk("pix5_y",  int'(bus.y),  -59);
                            chk("pix5_cb", int'(bus.cb), -27);
                            chk("pix5_cr", int'(bus.cr), -5);
                        end
                        if (e.pat0 && e.idx == 63) begin
                            chk("pix63_y",  int'(bus.y),  -1);
                            chk("pix63_cb", int'(bus.cb), 31);
                            chk("pix63_cr", int'(bus.cr), -63);
                        end
`ifdef PIX_COORD_EN
                        chk("col_o", int'(bus.col_o), e.idx % 8);
                        chk("row_o", int'(bus.row_o), e.idx / 8);
                        if (e.idx == 42) begin
                            chk("pix42_row", int'(bus.row_o), 5);
                            chk("pix42_col", int'(bus.col_o), 2);
                        end
`endif
                        if (e.idx == 0) first_cyc = cyc;
                        if (e.idx == 63) begin
                            if (contig_en) chk("contiguous", cyc - first_cyc, 63);
                            mcu_out++;
                            $display("[TB] MCU out #%0d complete at cycle %0d", mcu_out, cyc);
                        end
                    end
                end else begin
                    prev_stall = 1'b1;
                    hy  = bus.y;
                    hcb = bus.cb;
                    hcr = bus.cr;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Feed one MCU (or its first max_s samples); push expectations when complete
    task automatic send_mcu(input int vld_pct, input int max_s);
        int s     = 0;
        int tries = 0;
        while (s < max_s && s < 192) begin
            @(posedge clk);
            #1;
            bus.din_vld = ($urandom_range(0, 99) < vld_pct);
            bus.din     = pix(mcu_n, s / 64, s % 64);
            @(negedge clk);
            if (bus.din_vld && bus.din_rdy) begin
                s++;
                tries = 0;
            end else begin
                if (bus.din_vld) stalls++;
                tries++;
                if (tries > 4000) begin
                    chk("din_rdy_timeout", 0, 1);
                    bus.din_vld = 1'b0;
                    return;
                end
            end
        end
        if (s == 192) begin
            for (int i = 0; i < 64; i++) begin
                exp_t e;
                e.y    = pix(mcu_n, 0, i);
                e.cb   = pix(mcu_n, 1, i);
                e.cr   = pix(mcu_n, 2, i);
                e.last = (i == 63);
                e.idx  = i;
                e.pat0 = (mcu_n == 0);
                sb.push_back(e);
            end
            $display("[TB] MCU in  #%0d accepted at cycle %0d", mcu_n, cyc);
            mcu_n++;
        end
    endtask

    task automatic idle_din();
        @(posedge clk);
        #1;
        bus.din_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.din_vld = 1'b0;
        sb.delete();
        mcu_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vld_o",   int'(bus.vld_o),   0);
        chk("rst_din_rdy", int'(bus.din_rdy), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int prev_rdy;
        bus.din     = '0;
        bus.din_vld = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_vld_o",   int'(bus.vld_o),   0);
        chk("reset_last_o",  int'(bus.last_o),  0);
        chk("reset_y",       int'(bus.y),       0);
        chk("reset_din_rdy", int'(bus.din_rdy), 1);

        // Single MCU, latency and contiguity
        rdy_mode  = 1;
        contig_en = 1'b1;
        mcu_n     = 0;
        send_mcu(100, 192);
        idle_din();
        @(negedge clk);
        chk("lat_vld_early", int'(bus.vld_o), 0);
        @(negedge clk);
        chk("lat_vld",       int'(bus.vld_o), 1);
        drain();

        // Three back-to-back MCUs, no input stalls
        stalls = 0;
        repeat (3) send_mcu(100, 192);
        idle_din();
        chk("no_in_stall", stalls, 0);
        drain();

        // Downstream stalled while feeding three MCUs
        contig_en = 1'b0;
        rdy_mode  = 0;
        mcu_n     = 0;
        repeat (2) @(posedge clk);
        repeat (2) send_mcu(100, 192);
        idle_din();
        @(negedge clk);
        chk("full_din_rdy", int'(bus.din_rdy), 0);
        chk("frozen_vld",   int'(bus.vld_o),   1);
        chk("frozen_y",     int'(bus.y),       -64);
        chk("frozen_cb",    int'(bus.cb),      -32);
        chk("frozen_cr",    int'(bus.cr),      0);
        fork
            send_mcu(100, 192);
            begin
                repeat (4) @(posedge clk);
                rdy_mode = 1;
                t        = 0;
                prev_rdy = int'(bus.din_rdy);
                while (!bus.last_o && t < 300) begin
                    prev_rdy = int'(bus.din_rdy);
                    @(negedge clk);
                    t++;
                end
                chk("last_seen",     int'(bus.last_o),  1);
                chk("din_rdy_rise",  int'(bus.din_rdy), 1);
                chk("din_rdy_prior", prev_rdy,          0);
            end
        join
        idle_din();
        drain();

        // Random handshakes on both sides
        rdy_mode = 2;
        for (int m = 0; m < 20; m++) send_mcu(70, 192);
        idle_din();
        drain();

        // Reset mid-input and mid-output
        rdy_mode = 1;
        mcu_n    = 0;
        send_mcu(100, 100);
        idle_din();
        pulse_reset();
        repeat (2) send_mcu(100, 192);
        idle_din();
        repeat (20) @(posedge clk);
        #1;
        chk("mid_mcu1_vld", int'(bus.vld_o), 1);
        pulse_reset();
        send_mcu(100, 192);
        idle_din();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
